// File: rtl/param_rx_pkg.sv
// Shared types and constants for the parameter RX frame writer.
package param_rx_pkg;
    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         LEN_W         = 8;
    localparam int         RAM_AW        = 11;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/param_rx_word_packer.sv
// Packs bytes LSB-first into 32-bit words; word_ready/word_dat are valid combinationally
// in the cycle the 4th byte of a word is presented, so the caller can register the write.
module param_rx_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [31:0] word_dat,
    output logic        word_ready
);
    logic [23:0] shreg;
    logic [1:0]  byte_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
        end else if (byte_vld) begin
            shreg    <= {byte_dat, shreg[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_dat   = {byte_dat, shreg};
    assign word_ready = byte_vld && (byte_cnt == 2'd3);
endmodule

// File: rtl/param_rx_frame_writer.sv
// Framed byte-stream receiver writing 32-bit words to RX RAM s2; write one cycle after 4th byte,
// commit one cycle after CSUM; never backpressures. Ping-pong banking with PARAM_RX_PINGPONG_EN.
module param_rx_frame_writer
    import param_rx_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 1000,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic [RAM_AW-1:0]   ram_s2_address,
    output logic                ram_s2_chipselect,
    output logic                ram_s2_clken,
    output logic                ram_s2_write,
    output logic [31:0]         ram_s2_writedata,
    output logic [3:0]          ram_s2_byteenable,
    output logic                loop_gpio,
    output logic [LEN_W-1:0]    frame_words,
    output logic                frame_bank,
    output logic [7:0]          err_count,
    output logic                busy
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    rx_state_t        state, state_nxt;
    logic             run;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] word_idx;
    logic [7:0]       sum;
    logic [TW-1:0]    tmo_cnt;
    logic             wbank;
    logic             accept, timeout, commit, frame_err;
    logic             pk_vld, pk_ready;
    logic [31:0]      pk_word;

    assign rx_ready     = run;
    assign ram_s2_clken = run;
    assign accept       = rx_valid && rx_ready;
    assign busy         = (state != ST_HUNT);
    assign timeout      = busy && !accept && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign pk_vld       = accept && (state == ST_PAYLOAD);

    param_rx_word_packer u_packer (
        .clk        (clk_clk),
        .rst        (reset_reset),
        .clr        (state != ST_PAYLOAD),
        .byte_vld   (pk_vld),
        .byte_dat   (rx_data),
        .word_dat   (pk_word),
        .word_ready (pk_ready)
    );

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= ST_HUNT;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        frame_err = 1'b0;
        if (timeout) begin
            state_nxt = ST_HUNT;
            frame_err = 1'b1;
        end else begin
            case (state)
                ST_HUNT:    if (accept && rx_data == SYNC_BYTE) state_nxt = ST_LEN;
                ST_LEN: begin
                    if (accept) begin
                        if (rx_data == 8'h00) begin
                            state_nxt = ST_HUNT;
                            frame_err = 1'b1;
                        end else begin
                            state_nxt = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: if (pk_ready && word_idx == len - 8'd1) state_nxt = ST_CSUM;
                ST_CSUM: begin
                    if (accept) begin
                        state_nxt = ST_HUNT;
                        if ((sum + rx_data) == 8'h00) commit    = 1'b1;
                        else                          frame_err = 1'b1;
                    end
                end
                default:    state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            run               <= 1'b0;
            len               <= '0;
            word_idx          <= '0;
            sum               <= '0;
            tmo_cnt           <= '0;
            ram_s2_address    <= '0;
            ram_s2_chipselect <= 1'b0;
            ram_s2_write      <= 1'b0;
            ram_s2_writedata  <= '0;
            ram_s2_byteenable <= 4'h0;
            loop_gpio         <= 1'b0;
            frame_words       <= '0;
            err_count         <= '0;
        end else begin
            run               <= 1'b1;
            ram_s2_write      <= pk_ready;
            ram_s2_chipselect <= pk_ready;
            ram_s2_byteenable <= {4{pk_ready}};
            // Inter-byte gap counter only matters while a frame is open
            if (!busy || accept) tmo_cnt <= '0;
            else                 tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ST_LEN && accept) begin
                len      <= rx_data;
                word_idx <= '0;
                sum      <= rx_data;
            end
            if (pk_vld) sum <= sum + rx_data;
            if (pk_ready) begin
                ram_s2_address   <= {wbank, 2'b00, word_idx};
                ram_s2_writedata <= pk_word;
                word_idx         <= word_idx + 8'd1;
            end
            if (commit) begin
                frame_words <= len;
                loop_gpio   <= ~loop_gpio;
            end
            if (frame_err) err_count <= sat_inc8(err_count);
        end
    end

`ifdef PARAM_RX_PINGPONG_EN
    // Receive into the bank opposite the last committed frame
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wbank      <= 1'b0;
            frame_bank <= 1'b0;
        end else begin
            if (state == ST_HUNT && accept && rx_data == SYNC_BYTE) wbank <= ~frame_bank;
            if (commit) frame_bank <= wbank;
        end
    end
`else
    assign wbank      = 1'b0;
    assign frame_bank = 1'b0;
`endif
endmodule

// File: tb/tb_param_rx_frame_writer.sv
// Directed bench for param_rx_frame_writer: good/bad frames, LEN=0, timeout, back-to-back, reset abort.
module tb_param_rx_frame_writer;
    typedef logic [7:0] bq_t[$];

    localparam int TMO = 1000;
`ifdef PARAM_RX_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [10:0] ram_s2_address;
    logic        ram_s2_chipselect, ram_s2_clken, ram_s2_write;
    logic [31:0] ram_s2_writedata;
    logic [3:0]  ram_s2_byteenable;
    logic        loop_gpio, frame_bank, busy;
    logic [7:0]  frame_words, err_count;

    int tests = 0;
    int fails = 0;
    logic [10:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [4:0]  wq_ctl[$];
    logic        exp_fb, exp_gpio, bank, bank2;
    bq_t fa, fa_bad, flen0, ftmo, fb, fpart;

    always #5 clk = ~clk;

    param_rx_frame_writer #(.TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk_clk           (clk),
        .reset_reset       (rst),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .ram_s2_address    (ram_s2_address),
        .ram_s2_chipselect (ram_s2_chipselect),
        .ram_s2_clken      (ram_s2_clken),
        .ram_s2_write      (ram_s2_write),
        .ram_s2_writedata  (ram_s2_writedata),
        .ram_s2_byteenable (ram_s2_byteenable),
        .loop_gpio         (loop_gpio),
        .frame_words       (frame_words),
        .frame_bank        (frame_bank),
        .err_count         (err_count),
        .busy              (busy)
    );

    always @(negedge clk) begin
        if (ram_s2_write) begin
            wq_addr.push_back(ram_s2_address);
            wq_data.push_back(ram_s2_writedata);
            wq_ctl.push_back({ram_s2_chipselect, ram_s2_byteenable});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_seq(input bq_t q);
        foreach (q[i]) send(q[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_log();
        wq_addr.delete();
        wq_data.delete();
        wq_ctl.delete();
    endtask

    task automatic check_wr(input int i, input logic bk, input logic [7:0] idx, input logic [31:0] d);
        logic [10:0] a;
        logic [31:0] dd;
        logic [4:0]  c;
        a = 'x; dd = 'x; c = 'x;
        if (i < wq_addr.size()) begin
            a = wq_addr[i]; dd = wq_data[i]; c = wq_ctl[i];
        end
        check($sformatf("wr%0d_addr", i), 32'(a), 32'({bk, 2'b00, idx}));
        check($sformatf("wr%0d_data", i), dd, d);
        check($sformatf("wr%0d_ctl", i), 32'(c), 32'h1F);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_rx_ready"}, 32'(rx_ready), 0);
        check({pfx, "_clken"}, 32'(ram_s2_clken), 0);
        check({pfx, "_write"}, 32'({ram_s2_write, ram_s2_chipselect, ram_s2_byteenable}), 0);
        check({pfx, "_addr_data"}, 32'(ram_s2_address) | ram_s2_writedata, 0);
        check({pfx, "_gpio"}, 32'(loop_gpio), 0);
        check({pfx, "_words"}, 32'(frame_words), 0);
        check({pfx, "_bank"}, 32'(frame_bank), 0);
        check({pfx, "_err"}, 32'(err_count), 0);
        check({pfx, "_busy"}, 32'(busy), 0);
    endtask

    function automatic logic next_bank();
        return PP ? ~exp_fb : 1'b0;
    endfunction

    initial begin
        // Sum of LEN+payload+CSUM must be 0 mod 256: 02+1..8 = 26h -> DA
        fa     = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hDA};
        fa_bad = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hDB};
        flen0  = '{8'h33, 8'hA5, 8'h00};
        ftmo   = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33};
        fb     = '{8'h00, 8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hF1};
        fpart  = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        exp_fb = 1'b0; exp_gpio = 1'b0;
        #12;
        check_reset_state("rst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_clken", 32'(ram_s2_clken), 1);
        check("post_rst_ready", 32'(rx_ready), 1);
        check("post_rst_busy", 32'(busy), 0);

        // Good frame
        clr_log(); bank = next_bank();
        send_seq(fa);
        exp_gpio = ~exp_gpio; if (PP) exp_fb = bank;
        check("good_nwr", wq_addr.size(), 2);
        check_wr(0, bank, 8'd0, 32'h04030201);
        check_wr(1, bank, 8'd1, 32'h08070605);
        check("good_gpio", 32'(loop_gpio), 32'(exp_gpio));
        check("good_words", 32'(frame_words), 2);
        check("good_bank", 32'(frame_bank), 32'(exp_fb));
        check("good_err", 32'(err_count), 0);
        check("good_busy", 32'(busy), 0);

        // Bad checksum: words land, no commit
        clr_log(); bank = next_bank();
        send_seq(fa_bad);
        check("bad_nwr", wq_addr.size(), 2);
        check_wr(0, bank, 8'd0, 32'h04030201);
        check("bad_gpio", 32'(loop_gpio), 32'(exp_gpio));
        check("bad_bank", 32'(frame_bank), 32'(exp_fb));
        check("bad_err", 32'(err_count), 1);

        // LEN = 0 after a discarded hunt byte
        clr_log();
        send_seq(flen0);
        idle(2);
        check("len0_nwr", wq_addr.size(), 0);
        check("len0_err", 32'(err_count), 2);
        check("len0_busy", 32'(busy), 0);

        // Timeout after 3 payload bytes: still open after TMO-1 idle clocks, closed after TMO
        clr_log();
        send_seq(ftmo);
        check("tmo_busy_mid", 32'(busy), 1);
        idle(TMO - 1);
        check("tmo_busy_edge", 32'(busy), 1);
        check("tmo_err_edge", 32'(err_count), 2);
        idle(1);
        check("tmo_busy_done", 32'(busy), 0);
        check("tmo_err", 32'(err_count), 3);
        check("tmo_nwr", wq_addr.size(), 0);
        bank = next_bank();
        send_seq(fb);
        exp_gpio = ~exp_gpio; if (PP) exp_fb = bank;
        check("after_tmo_nwr", wq_addr.size(), 1);
        check_wr(0, bank, 8'd0, 32'hDDCCBBAA);
        check("after_tmo_gpio", 32'(loop_gpio), 32'(exp_gpio));
        check("after_tmo_words", 32'(frame_words), 1);
        check("after_tmo_err", 32'(err_count), 3);

        // Back-to-back good frames, no idle gap
        clr_log();
        bank = next_bank();
        send_seq(fa);
        exp_gpio = ~exp_gpio; if (PP) exp_fb = bank;
        check("b2b1_gpio", 32'(loop_gpio), 32'(exp_gpio));
        check("b2b1_bank", 32'(frame_bank), 32'(exp_fb));
        bank2 = next_bank();
        send_seq(fa);
        exp_gpio = ~exp_gpio; if (PP) exp_fb = bank2;
        check("b2b2_gpio", 32'(loop_gpio), 32'(exp_gpio));
        check("b2b2_bank", 32'(frame_bank), 32'(exp_fb));
        check("b2b_nwr", wq_addr.size(), 4);
        check_wr(1, bank, 8'd1, 32'h08070605);
        check_wr(2, bank2, 8'd0, 32'h04030201);
        check("b2b_err", 32'(err_count), 3);

        // Reset mid-payload aborts the frame
        send_seq(fpart);
        check("part_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        exp_fb = 1'b0; exp_gpio = 1'b0;
        clr_log(); bank = next_bank();
        send_seq(fa);
        exp_gpio = ~exp_gpio; if (PP) exp_fb = bank;
        check("rec_nwr", wq_addr.size(), 2);
        check_wr(1, bank, 8'd1, 32'h08070605);
        check("rec_gpio", 32'(loop_gpio), 32'(exp_gpio));
        check("rec_words", 32'(frame_words), 2);
        check("rec_bank", 32'(frame_bank), 32'(exp_fb));
        check("rec_err", 32'(err_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
